branch_target_unit: RTL and testbench
=====================================

Name: branch_target_unit

Overview:
- Sits directly downstream of the branch extender in the ARMSIM core.
- Consumes the 32-bit sign-extended, word-shifted branch offset and the address of the B/BL instruction, and evaluates the ARM condition field against the NZCV flags.
- Owns the program counter: it either advances sequentially or redirects to the branch target.
- On a taken branch it flushes the wrong-path fetches and, for BL, emits the link-register write.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch (1..7)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC, no fetch advance
br_req  input  1  decode stage presents a B/BL this cycle
br_cond  input  4  ARM condition field [31:28]
br_link  input  1  1 = BL
br_pc  input  32  address of the branch instruction
br_offset  input  32  extender output (sign-extended, <<2)
flags_nzcv  input  4  {N,Z,C,V} from CPSR
pc  output  32  current fetch address
fetch_valid  output  1  pc is a valid fetch this cycle
flush  output  1  invalidate fetch/decode contents
br_taken  output  1  one-cycle pulse on taken branch
lr_we  output  1  one-cycle link-register write enable
lr_data  output  32  return address for BL

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - pc=RESET_VECTOR; state=BOOT; counter=0.
  - fetch_valid=0, flush=0, br_taken=0, lr_we=0, lr_data=0.
  - Reset mid-FLUSH aborts the flush immediately.
- States: BOOT, RUN, FLUSH. All transitions occur on the rising edge of clk.
- BOOT: lasts one cycle after reset release; fetch_valid=0; br_req ignored; next state RUN. pc is unchanged.
- RUN:
  - fetch_valid = !stall.
  - Condition true (cond_ok):
    - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
    - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
    - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
    - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never taken.
  - br_req & cond_ok, taken (priority over stall):
    - pc <= br_pc + 32'd8 + br_offset, mod 2^32 with no overflow flag; the +8 reflects the ARM pipeline PC.
    - Next cycle: br_taken=1 and state=FLUSH.
    - If br_link: lr_we=1 and lr_data=br_pc+4, both in that same cycle.
  - br_req with condition false: treated as a no-op; sequential update applies.
  - Otherwise: pc <= pc+4 if !stall, else pc holds. pc wraps 0xFFFF_FFFC -> 0x0000_0000.
- FLUSH:
  - flush=1 and fetch_valid=0 for exactly FLUSH_CYCLES cycles, counted by an internal down-counter.
  - br_req and stall are ignored; pc holds at the target.
  - Then return to RUN, where the first fetch is the target.
- br_taken and lr_we are registered pulses, high for exactly one cycle.
- lr_data holds its last value when lr_we=0.
- Latency: branch sampled in cycle N -> pc=target and br_taken in cycle N+1 -> flush in cycles N+1..N+FLUSH_CYCLES -> target fetch_valid in cycle N+FLUSH_CYCLES+1, when not stalled.
- Non-taken branches impose no bubble.

Test Plan:
- Reset, then 4 unstalled cycles -> one BOOT cycle with fetch_valid=0, then pc=0x0, 0x4, 0x8, 0xC with fetch_valid=1.
- Branch: br_req, cond=1110, br_pc=0x0000_1000, br_offset=0xFF55_5554 (extender output for 24'hD55555) -> pc=0xFF55_655C and br_taken for one cycle. Then flush=1 for 2 cycles, then fetch_valid=1 at 0xFF55_655C.
- Conditional: cond=0000 (EQ) with flags=4'b0000 -> not taken, pc+4, no flush. Repeat with flags=4'b0100 -> taken.
- Conditions GE/LT: flags=4'b1001 (N=V=1) with GE -> taken; LT -> not taken.
- BL: br_link=1, br_pc=0x200, br_offset=0x10 -> pc=0x218; lr_we=1 with lr_data=0x204 for exactly one cycle. br_req asserted during FLUSH is ignored.
- Stall and boundaries:
  - stall=1 for 3 cycles -> pc holds.
  - stall=1 with a taken branch -> branch still taken.
  - pc=0xFFFF_FFFC -> wraps to 0x0.
  - rst_n low in the middle of FLUSH -> immediately pc=RESET_VECTOR and flush=0.

Source files
------------

// File: rtl/branch_target_unit.sv
// Branch target unit: evaluates ARM condition codes against NZCV, owns the
// fetch PC, redirects on taken B/BL, flushes wrong-path fetches, emits LR write.
module branch_target_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_req,
    input  logic [3:0]  br_cond,
    input  logic        br_link,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    input  logic [3:0]  flags_nzcv,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        br_taken,
    output logic        lr_we,
    output logic [31:0] lr_data
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam logic [2:0] LP_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_br_taken;
    logic        w_br_taken_nxt;
    logic        r_lr_we;
    logic        w_lr_we_nxt;
    logic [31:0] r_lr_data;
    logic [31:0] w_lr_data_nxt;

    logic        w_n;
    logic        w_z;
    logic        w_c;
    logic        w_v;
    logic        w_cond_ok;
    logic        w_take;
    logic [31:0] w_target;
    logic [31:0] w_link;

    assign {w_n, w_z, w_c, w_v} = flags_nzcv;

    always_comb begin
        w_cond_ok = 1'b0;
        unique case (br_cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = !w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = !w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = !w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = !w_v;
            4'b1000: w_cond_ok = w_c && !w_z;
            4'b1001: w_cond_ok = !w_c || w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = !w_z && (w_n == w_v);
            4'b1101: w_cond_ok = w_z || (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            4'b1111: w_cond_ok = 1'b0;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // +8: the architectural PC seen by the branch is two instructions ahead
    assign w_target = br_pc + 32'd8 + br_offset;
    assign w_link   = br_pc + 32'd4;
    assign w_take   = br_req && w_cond_ok;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_br_taken_nxt = 1'b0;
        w_lr_we_nxt    = 1'b0;
        w_lr_data_nxt  = r_lr_data;
        unique case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_take) begin
                    w_pc_nxt       = w_target;
                    w_br_taken_nxt = 1'b1;
                    w_cnt_nxt      = LP_FLUSH_LOAD;
                    w_state_nxt    = ST_FLUSH;
                    if (br_link) begin
                        w_lr_we_nxt   = 1'b1;
                        w_lr_data_nxt = w_link;
                    end
                end else if (!stall) begin
                    w_pc_nxt = r_pc + 32'd4;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_cnt      <= 3'd0;
            r_br_taken <= 1'b0;
            r_lr_we    <= 1'b0;
            r_lr_data  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_br_taken <= w_br_taken_nxt;
            r_lr_we    <= w_lr_we_nxt;
            r_lr_data  <= w_lr_data_nxt;
        end
    end

    assign pc          = r_pc;
    assign fetch_valid = (r_state == ST_RUN) && !stall;
    assign flush       = (r_state == ST_FLUSH);
    assign br_taken    = r_br_taken;
    assign lr_we       = r_lr_we;
    assign lr_data     = r_lr_data;

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit: boot, B/BL redirect, conditions,
// flush window, stall, PC wrap and reset during flush.
module tb_branch_target_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_req;
    logic [3:0]  br_cond;
    logic        br_link;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic [3:0]  flags_nzcv;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        br_taken;
    logic        lr_we;
    logic [31:0] lr_data;

    int n_checks;
    int n_errors;

    branch_target_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_req     (br_req),
        .br_cond    (br_cond),
        .br_link    (br_link),
        .br_pc      (br_pc),
        .br_offset  (br_offset),
        .flags_nzcv (flags_nzcv),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .flush      (flush),
        .br_taken   (br_taken),
        .lr_we      (lr_we),
        .lr_data    (lr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cond, input logic link,
                         input logic [31:0] bpc, input logic [31:0] off);
        br_req    = 1'b1;
        br_cond   = cond;
        br_link   = link;
        br_pc     = bpc;
        br_offset = off;
    endtask

    task automatic idle();
        br_req  = 1'b0;
        br_link = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (pc !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
        end
        n_checks++;
        if ({fetch_valid, flush, br_taken, lr_we} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_outs: got %b want 0000",
                     {fetch_valid, flush, br_taken, lr_we});
        end
        n_checks++;
        if (lr_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_lr_data: got %h want 0", lr_data);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b0 || pc !== 32'h0) begin
            n_errors++;
            $display("FAIL boot_cycle: got fv=%b pc=%h want fv=0 pc=0",
                     fetch_valid, pc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (fetch_valid !== 1'b1 || pc !== 32'(i * 4)) begin
                n_errors++;
                $display("FAIL seq_fetch%0d: got fv=%b pc=%h want fv=1 pc=%h",
                         i, fetch_valid, pc, 32'(i * 4));
            end
        end
    endtask

    task automatic test_branch();
        issue(4'b1110, 1'b0, 32'h0000_1000, 32'hFF55_5554);
        tick();
        idle();
        n_checks++;
        if (pc !== 32'hFF55_655C || br_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL b_target: got pc=%h bt=%b want pc=ff55655c bt=1",
                     pc, br_taken);
        end
        n_checks++;
        if (flush !== 1'b1 || fetch_valid !== 1'b0 || lr_we !== 1'b0) begin
            n_errors++;
            $display("FAIL b_flush1: got fl=%b fv=%b lw=%b want 1 0 0",
                     flush, fetch_valid, lr_we);
        end
        tick();
        n_checks++;
        if (flush !== 1'b1 || br_taken !== 1'b0 || fetch_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b_flush2: got fl=%b bt=%b fv=%b want 1 0 0",
                     flush, br_taken, fetch_valid);
        end
        tick();
        n_checks++;
        if (flush !== 1'b0 || fetch_valid !== 1'b1 || pc !== 32'hFF55_655C) begin
            n_errors++;
            $display("FAIL b_refetch: got fl=%b fv=%b pc=%h want 0 1 ff55655c",
                     flush, fetch_valid, pc);
        end
    endtask

    task automatic test_cond_eq();
        flags_nzcv = 4'b0000;
        issue(4'b0000, 1'b0, 32'h0000_3000, 32'h0000_0020);
        tick();
        n_checks++;
        if (pc !== 32'hFF55_6560 || br_taken !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL eq_not_taken: got pc=%h bt=%b fl=%b want ff556560 0 0",
                     pc, br_taken, flush);
        end
        flags_nzcv = 4'b0100;
        tick();
        idle();
        n_checks++;
        if (pc !== 32'h0000_3028 || br_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL eq_taken: got pc=%h bt=%b want 00003028 1",
                     pc, br_taken);
        end
        tick();
        tick();
        n_checks++;
        if (pc !== 32'h0000_3028 || fetch_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL eq_refetch: got pc=%h fv=%b want 00003028 1",
                     pc, fetch_valid);
        end
    endtask

    task automatic test_cond_ge_lt();
        flags_nzcv = 4'b1001;
        issue(4'b1010, 1'b0, 32'h0000_4000, 32'h0000_0000);
        tick();
        idle();
        n_checks++;
        if (pc !== 32'h0000_4008 || br_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL ge_taken: got pc=%h bt=%b want 00004008 1",
                     pc, br_taken);
        end
        tick();
        tick();
        issue(4'b1011, 1'b0, 32'h0000_5000, 32'h0000_0100);
        tick();
        idle();
        n_checks++;
        if (pc !== 32'h0000_400C || br_taken !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL lt_not_taken: got pc=%h bt=%b fl=%b want 0000400c 0 0",
                     pc, br_taken, flush);
        end
    endtask

    task automatic test_bl();
        issue(4'b1110, 1'b1, 32'h0000_0200, 32'h0000_0010);
        tick();
        n_checks++;
        if (pc !== 32'h0000_0218 || lr_we !== 1'b1 || lr_data !== 32'h0000_0204) begin
            n_errors++;
            $display("FAIL bl_link: got pc=%h lw=%b ld=%h want 00000218 1 00000204",
                     pc, lr_we, lr_data);
        end
        issue(4'b1110, 1'b1, 32'h0000_8000, 32'h0000_0040);
        tick();
        idle();
        n_checks++;
        if (lr_we !== 1'b0 || lr_data !== 32'h0000_0204 || br_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL bl_pulse: got lw=%b ld=%h bt=%b want 0 00000204 0",
                     lr_we, lr_data, br_taken);
        end
        n_checks++;
        if (pc !== 32'h0000_0218 || flush !== 1'b1) begin
            n_errors++;
            $display("FAIL bl_flush_ignore: got pc=%h fl=%b want 00000218 1",
                     pc, flush);
        end
        tick();
        n_checks++;
        if (pc !== 32'h0000_0218 || fetch_valid !== 1'b1 || br_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL bl_refetch: got pc=%h fv=%b bt=%b want 00000218 1 0",
                     pc, fetch_valid, br_taken);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pc !== 32'h0000_0218 || fetch_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold%0d: got pc=%h fv=%b want 00000218 0",
                         i, pc, fetch_valid);
            end
        end
        issue(4'b1110, 1'b0, 32'h0000_0500, 32'h0000_0100);
        tick();
        idle();
        stall = 1'b0;
        n_checks++;
        if (pc !== 32'h0000_0608 || br_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_branch: got pc=%h bt=%b want 00000608 1",
                     pc, br_taken);
        end
        tick();
        tick();
        n_checks++;
        if (pc !== 32'h0000_0608 || fetch_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_refetch: got pc=%h fv=%b want 00000608 1",
                     pc, fetch_valid);
        end
    endtask

    task automatic test_wrap();
        issue(4'b1110, 1'b0, 32'h0000_0000, 32'hFFFF_FFF4);
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (pc !== 32'hFFFF_FFFC || fetch_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_top: got pc=%h fv=%b want fffffffc 1",
                     pc, fetch_valid);
        end
        tick();
        n_checks++;
        if (pc !== 32'h0000_0000 || fetch_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_zero: got pc=%h fv=%b want 00000000 1",
                     pc, fetch_valid);
        end
    endtask

    task automatic test_reset_mid_flush();
        issue(4'b1110, 1'b1, 32'h0000_0100, 32'h0000_0040);
        tick();
        idle();
        n_checks++;
        if (pc !== 32'h0000_0148 || flush !== 1'b1) begin
            n_errors++;
            $display("FAIL rmf_pre: got pc=%h fl=%b want 00000148 1", pc, flush);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pc !== 32'h0 || flush !== 1'b0 || br_taken !== 1'b0 || lr_we !== 1'b0) begin
            n_errors++;
            $display("FAIL rmf_abort: got pc=%h fl=%b bt=%b lw=%b want 0 0 0 0",
                     pc, flush, br_taken, lr_we);
        end
        n_checks++;
        if (lr_data !== 32'h0 || fetch_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rmf_lr: got ld=%h fv=%b want 0 0", lr_data, fetch_valid);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL rmf_boot: got fv=%b fl=%b want 0 0", fetch_valid, flush);
        end
        tick();
        n_checks++;
        if (pc !== 32'h0 || fetch_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rmf_run: got pc=%h fv=%b want 0 1", pc, fetch_valid);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        stall      = 1'b0;
        br_req     = 1'b0;
        br_cond    = 4'b1110;
        br_link    = 1'b0;
        br_pc      = 32'h0;
        br_offset  = 32'h0;
        flags_nzcv = 4'b0000;
        test_reset();
        test_branch();
        test_cond_eq();
        test_cond_ge_lt();
        test_bl();
        test_stall();
        test_wrap();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
